instr_fetch_stage: RTL and testbench

- IF stage of the 64-bit pipelined ARM CPU.
- Owns the PC, drives the byte address into the combinational instruction ROM, and registers the returned word into the IF/ID pipeline register.
- Handles hazard-unit stall, branch redirect/flush, and a fetch-fault state for bad fetch addresses.

---
 rtl/instr_fetch_stage_pkg.sv | 31 +++
 rtl/instr_fetch_stage_if.sv | 25 ++
 rtl/instr_fetch_stage_pc_register.sv | 37 +++
 rtl/instr_fetch_stage.sv | 109 ++++++++++
 tb/tb_instr_fetch_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch/decode types: FSM state encoding, the NOP bubble word and the IF/ID register layout.
package if_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP         = 32'hD503201F;
  localparam int          INSTR_BYTES = 4;

  // Reused unchanged by the decode stage as its input register layout
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic is_word_aligned(input logic [63:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  function automatic if_id_t bubble(input logic [63:0] pc);
    if_id_t b;
    b.pc    = pc;
    b.instr = NOP;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM address/data, IF/ID register contents out.
interface instr_fetch_stage_if;

  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fault;

  modport master (
    input  stall, redirect, redirect_target, imem_instruction,
    output imem_address, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fault
  );

  modport slave (
    output stall, redirect, redirect_target, imem_instruction,
    input  imem_address, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fault
  );

endinterface

// File: rtl/instr_fetch_stage_pc_register.sv
// 64-bit program counter: async reset to RESET_PC, load has priority over hold, otherwise +4 (modulo 2^64).
module pc_register
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic [63:0] target_i,
  output logic [63:0] pc_o
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (!hold_i) begin
      pc_d = pc_q + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC, combinational ROM address, IF/ID register, RUN/FAULT FSM. One-cycle fetch latency.
// Optional fetch-address bounds check enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch_stage
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_stage_if.master   bus
);

  fetch_state_t state_q, state_d;
  if_id_t       if_id_q, if_id_d;
  logic [63:0]  pc;
  logic         pc_load;
  logic         pc_hold;
  logic         out_of_bounds;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (reset),
    .load_i   (pc_load),
    .hold_i   (pc_hold),
    .target_i (bus.redirect_target),
    .pc_o     (pc)
  );

`ifdef FETCH_BOUNDS_CHECK_EN
  // Widened so PC values near 2^64 cannot wrap past the limit
  logic [64:0] last_byte;
  assign last_byte     = {1'b0, pc} + 65'd3;
  assign out_of_bounds = last_byte >= 65'(IMEM_SIZE);
`else
  assign out_of_bounds = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    pc_load = 1'b0;
    pc_hold = 1'b1;
    case (state_q)
      RUN: begin
        if (bus.redirect) begin
          // Flush wins over stall so the wrong-path word is discarded
          pc_load = 1'b1;
          pc_hold = 1'b0;
          if_id_d = bubble(pc);
          if (!is_word_aligned(bus.redirect_target)) begin
            state_d = FAULT;
          end
        end else if (bus.stall) begin
          if_id_d = if_id_q;
        end else if (out_of_bounds) begin
          if_id_d = bubble(pc);
          state_d = FAULT;
        end else begin
          pc_hold       = 1'b0;
          if_id_d.pc    = pc;
          if_id_d.instr = bus.imem_instruction;
          if_id_d.valid = 1'b1;
        end
      end
      FAULT: begin
        if_id_d.instr = NOP;
        if_id_d.valid = 1'b0;
      end
      default: begin
        state_d = FAULT;
        if_id_d = bubble(if_id_q.pc);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q <= bubble(64'h0);
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign bus.imem_address   = pc;
  assign bus.if_id_pc       = if_id_q.pc;
  assign bus.if_id_pc_plus4 = if_id_q.pc + 64'(INSTR_BYTES);
  assign bus.if_id_instr    = if_id_q.instr;
  assign bus.if_id_valid    = if_id_q.valid;
  assign bus.fault          = (state_q == FAULT);

`ifndef SYNTHESIS
  a_fault_is_bubble: assert property (@(posedge clk) disable iff (reset)
    (state_q == FAULT) |-> (!if_id_q.valid && if_id_q.instr == NOP));
  a_fault_pc_frozen: assert property (@(posedge clk) disable iff (reset)
    (state_q == FAULT) |=> $stable(pc));
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a per-edge behavioural model of the fetch rules.
module tb_instr_fetch_stage;
  import if_pkg::*;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          IMEM_SIZE = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(
    .RESET_PC  (RESET_PC),
    .IMEM_SIZE (IMEM_SIZE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [256];
  assign bus.imem_instruction = (bus.imem_address < 64'(IMEM_SIZE)) ?
                                rom[bus.imem_address[9:2]] : 32'hxxxxxxxx;

  // Reference model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid, m_fault, m_instr_x;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ifpc = 64'h0; m_instr = NOP;
    m_valid = 1'b0; m_fault = 1'b0; m_instr_x = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [63:0] tgt);
    logic bounds_hit;
    if (m_fault) return;
`ifdef FETCH_BOUNDS_CHECK_EN
    bounds_hit = ({1'b0, m_pc} + 65'd3) >= 65'(IMEM_SIZE);
`else
    bounds_hit = 1'b0;
`endif
    if (rd) begin
      m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0; m_instr_x = 1'b0;
      m_pc = tgt;
      if (tgt % 4 != 0) m_fault = 1'b1;
    end else if (st) begin
      // everything holds
    end else if (bounds_hit) begin
      m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0; m_instr_x = 1'b0;
      m_fault = 1'b1;
    end else begin
      m_ifpc = m_pc; m_valid = 1'b1;
      if (m_pc < 64'(IMEM_SIZE)) begin
        m_instr = rom[m_pc / 4]; m_instr_x = 1'b0;
      end else begin
        m_instr = 32'h0; m_instr_x = 1'b1;
      end
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".addr"},  bus.imem_address,   m_pc);
    check_eq({tag, ".ifpc"},  bus.if_id_pc,       m_ifpc);
    check_eq({tag, ".plus4"}, bus.if_id_pc_plus4, m_ifpc + 64'd4);
    check_eq({tag, ".valid"}, 64'(bus.if_id_valid), 64'(m_valid));
    check_eq({tag, ".fault"}, 64'(bus.fault),     64'(m_fault));
    if (!m_instr_x) check_eq({tag, ".instr"}, 64'(bus.if_id_instr), 64'(m_instr));
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic cycle(input logic st, input logic rd, input logic [63:0] tgt, input string tag);
    bus.stall = st; bus.redirect = rd; bus.redirect_target = tgt;
    @(posedge clk);
    model_edge(st, rd, tgt);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'h0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'h0;
    reset = 1'b1;
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Free run over W0..W3
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'h0, "run");
    check_eq("run.last_pc", bus.if_id_pc, 64'd12);
    check_eq("run.last_w", 64'(bus.if_id_instr), 64'(rom[3]));

    // Stall three cycles at PC=8
    do_reset("rst1");
    cycle(1'b0, 1'b0, 64'h0, "pre_stall");
    cycle(1'b0, 1'b0, 64'h0, "pre_stall");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0, "stall");
    check_eq("stall.addr_held", bus.imem_address, 64'd8);
    cycle(1'b0, 1'b0, 64'h0, "release");
    check_eq("release.ifpc", bus.if_id_pc, 64'd8);

    // Redirect combined with stall at PC=12
    cycle(1'b1, 1'b1, 64'h40, "redir_stall");
    check_eq("redir.nop", 64'(bus.if_id_instr), 64'hD503201F);
    cycle(1'b0, 1'b0, 64'h0, "after_redir");
    check_eq("after_redir.ifpc", bus.if_id_pc, 64'h40);

    // Back-to-back redirects
    cycle(1'b0, 1'b1, 64'h100, "redir2a");
    cycle(1'b0, 1'b1, 64'h200, "redir2b");
    cycle(1'b0, 1'b0, 64'h0, "redir2c");

    // Misaligned redirect then FAULT ignores everything
    cycle(1'b0, 1'b1, 64'h42, "misalign");
    for (int i = 0; i < 5; i++)
      cycle(1'(i % 2), 1'(i % 3 == 0), 64'h80, "fault_hold");
    check_eq("fault.pc_frozen", bus.imem_address, 64'h42);
    do_reset("rst_fault");

    // Walk off the end of the ROM
    cycle(1'b0, 1'b1, 64'd1020, "edge_redir");
    cycle(1'b0, 1'b0, 64'h0, "edge_w255");
    cycle(1'b0, 1'b0, 64'h0, "edge_past");
    cycle(1'b0, 1'b0, 64'h0, "edge_past2");

    // 64-bit PC wrap
    do_reset("rst_wrap");
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "wrap_redir");
    cycle(1'b0, 1'b0, 64'h0, "wrap_a");
    cycle(1'b0, 1'b0, 64'h0, "wrap_b");

    // Async reset in the middle of a redirect cycle
    do_reset("rst_pre");
    cycle(1'b0, 1'b0, 64'h0, "pre_async");
    bus.redirect = 1'b1; bus.redirect_target = 64'h80;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_mid");
    @(negedge clk);
    bus.redirect = 1'b0;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 64'h0, "post_async");
    check_eq("post_async.ifpc", bus.if_id_pc, RESET_PC);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic        st, rd;
      logic [63:0] tgt;
      int          r;
      r   = int'($urandom_range(0, 99));
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 12);
      tgt = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
      if (r < 4)      tgt[1:0] = 2'($urandom_range(1, 3));
      else if (r < 8) tgt = {62'h3FFF_FFFF_FFFF_FFFF - 62'($urandom_range(0, 3)), 2'b00};
      else if (r < 14) tgt = 64'd1024 - 64'({$urandom_range(1, 4), 2'b00});
      if ((m_fault && r < 30) || r == 99) do_reset("rnd_rst");
      else cycle(st, rd, tgt, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
